mio_bus_responder: RTL and testbench
====================================

# mio_bus_responder

Target-side responder for the CPU memory/IO bus. The multi-cycle CPU issues one request at a time using `CPU_MIO`, `mem_w`, the address and the write data, then stalls until `MIO_ready`. This block sits between that CPU and the system's storage and peripherals. It decodes the address, serves the request from an internal word RAM or a small peripheral register set, inserts the configured wait states, and returns read data together with a one-cycle ready pulse.

## Interface
- `RAM_DEPTH`, default 1024: RAM size in 32-bit words; must be a power of two.
- `RAM_WAIT`, default 2: wait cycles added to every RAM access; 0 is legal.

- `clk` input 1: system clock; every register updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `CPU_MIO` input 1: request valid; the CPU holds it high until it sees `MIO_ready`.
- `mem_w` input 1: 1 = write, 0 = read; sampled when the request is accepted.
- `Addr_out` input 32: byte address from the CPU; bits [1:0] are ignored.
- `Data_out` input 32: write data from the CPU.
- `Data_in` output 32: read data returned to the CPU; registered.
- `MIO_ready` output 1: transfer-complete pulse, high for exactly one cycle.
- `sw_in` input 16: switch inputs.
- `led_out` output 16: LED register value.
- `state` output 2: current FSM state (IDLE=0, WAIT=1, ACK=2), for debug.

## Operation
- **Address map** (word-aligned):
  - RAM: 0x0000_0000 to RAM_DEPTH*4-1.
  - LED register: 0xE000_0000, read/write; only bits [15:0] are stored; reads return zero in [31:16].
  - Switches: 0xF000_0000, read-only; returns {16'h0, sw_in}.
  - Counter: 0xF000_0004, read/write.
  - Unmapped addresses: reads return 0x0000_0000; writes are dropped; the request is still acknowledged.
- **Counter:** free-running 32-bit, increments every cycle and wraps from 0xFFFF_FFFF to 0. A write loads `Data_out`, and the load takes priority over that cycle's increment.
- **FSM:**
  - IDLE: when `CPU_MIO`=1, latch the address, write data and `mem_w`. Go to WAIT if the target is RAM and RAM_WAIT>0; otherwise go to ACK. When `CPU_MIO`=0, stay in IDLE.
  - WAIT: a down-counter loaded with RAM_WAIT-1 on entry. Stay while it is nonzero; when it reaches 0, go to ACK.
  - ACK: `MIO_ready`=1. Writes commit in this cycle. For reads, `Data_in` is loaded on the edge entering ACK and is valid throughout ACK. Next state is always IDLE.
- Every transaction uses only the values latched in IDLE. Changes on the bus inputs after acceptance have no effect.
- Each accepted request commits exactly one write or performs exactly one read.
- A request still asserted in the cycle after ACK starts a new transaction. This supports back-to-back fetch then load/store.
- `Data_in` holds its last value until the next read completes. Writes leave `Data_in` unchanged.
- Counter reads return the value sampled on the edge entering ACK.
- `CPU_MIO` dropping during WAIT does not abort the transaction; it still completes and acknowledges.

## Timing
- **Reset values:** state=IDLE, `MIO_ready`=0, `Data_in`=0, `led_out`=0, counter=0, wait counter=0. RAM contents are not reset.
- **Latency,** with the request accepted at edge t:
  - Peripheral or unmapped target: `MIO_ready` is high in the cycle following edge t.
  - RAM target: `MIO_ready` is high in the cycle following edge t+RAM_WAIT.
- **Minimum spacing:** two consecutive ready pulses are at least 2 cycles apart, since IDLE always sits between ACKs.
- **Reset mid-transaction:**
  - Returns to IDLE immediately.
  - A pending write is discarded, and no ready pulse is generated.
- **Simultaneous events:**
  - A RAM write and read to the same address cannot overlap.
  - A counter write in ACK and the counter increment in the same cycle resolve as load.
- The RAM is inferred as synchronous single-port; the read is issued at the final WAIT cycle or at acceptance so that data is present on the edge entering ACK.

## Test plan
- **Reset:** with `CPU_MIO`=0, pulse `reset` asynchronously mid-cycle -> `state`=0, `MIO_ready`=0, `Data_in`=0, `led_out`=0 with no clock edge needed.
- **RAM write/read, RAM_WAIT=2:**
  - Write 0x1234_5678 to 0x0000_0010 -> ready 3 cycles after acceptance.
  - Read the same address -> `Data_in`=0x1234_5678 while ready=1.
  - Exactly one ready pulse per request.
- **Peripherals:**
  - Write 0xABCD_00FF to 0xE000_0000 -> `led_out`=0x00FF; ready 1 cycle after acceptance.
  - Set `sw_in`=0x5A5A and read 0xF000_0000 -> 0x0000_5A5A.
- **Counter:**
  - Write 0xFFFF_FFFE, then read back after 4 idle cycles -> value wrapped through 0.
  - Reads return a monotonic difference matching the elapsed cycles.
- **Unmapped and back-to-back:**
  - Write to 0x8000_0000 -> acknowledged; no RAM or LED change. Read -> 0.
  - Hold `CPU_MIO` high through 3 requests -> ready pulses separated by IDLE; no duplicate writes.
- **Reset during WAIT:** issue a RAM write and assert `reset` in the WAIT cycle -> no ready pulse, and a later read of that address returns its old value.

Source files
------------

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: target-side responder for the multi-cycle CPU memory/IO bus.
// Decodes the request address, serves it from a word RAM or a small peripheral
// register set (LEDs, switches, free-running counter), inserts RAM wait states
// and answers with registered read data plus a one-cycle MIO_ready pulse.
module mio_bus_responder #(
    parameter int RAM_DEPTH = 1024,
    parameter int RAM_WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [1:0]  state
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int WW = (RAM_WAIT > 2) ? $clog2(RAM_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = (RAM_WAIT > 0) ? WW'(RAM_WAIT - 1) : '0;

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] LED_WORD = 30'h3800_0000;
    localparam logic [29:0] SW_WORD  = 30'h3C00_0000;
    localparam logic [29:0] CNT_WORD = 30'h3C00_0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [29:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            ready_q, ready_d;
    logic [31:0]     data_in_q, data_in_d;
    logic            rd_ram_q, rd_ram_d;
    logic [15:0]     led_q, led_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     ram_rd_q;
    logic [31:0]     mem [RAM_DEPTH];

    logic [29:0]     cur_word;
    logic            cur_we, cur_ram, cur_led, cur_sw, cur_cnt;
    logic [AW-1:0]   ram_idx;
    logic            ram_re, ram_we;
    logic [31:0]     periph_rdata;
    logic            addr_lsb_unused;

    assign addr_lsb_unused = ^Addr_out[1:0];

    // In IDLE the request is decoded straight off the bus; afterwards only the
    // latched copy is used, so bus changes after acceptance are ignored.
    assign cur_word = (state_q == S_IDLE) ? Addr_out[31:2] : addr_q;
    assign cur_we   = (state_q == S_IDLE) ? mem_w : we_q;
    assign cur_ram  = (cur_word[29:AW] == '0);
    assign cur_led  = (cur_word == LED_WORD);
    assign cur_sw   = (cur_word == SW_WORD);
    assign cur_cnt  = (cur_word == CNT_WORD);
    assign ram_idx  = cur_word[AW-1:0];

    // Next-state logic for the transaction FSM, LED register and counter.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wait_cnt_d = wait_cnt_q;
        ready_d    = 1'b0;
        led_d      = led_q;
        cnt_d      = cnt_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (CPU_MIO) begin
                    addr_d  = Addr_out[31:2];
                    wdata_d = Data_out;
                    we_d    = mem_w;
                    if (cur_ram && (RAM_WAIT > 0)) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = S_ACK;
                        ready_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_ACK;
                    ready_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (we_q) begin
                    if (cur_led) led_d = wdata_q[15:0];
                    // A counter load wins over this cycle's increment.
                    if (cur_cnt) cnt_d = wdata_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-data selection on the edge entering ACK; writes leave Data_in alone.
    always_comb begin
        periph_rdata = 32'h0;
        if (cur_led)      periph_rdata = {16'h0, led_q};
        else if (cur_sw)  periph_rdata = {16'h0, sw_in};
        else if (cur_cnt) periph_rdata = cnt_q;
        ram_re    = ready_d && !cur_we && cur_ram;
        ram_we    = (state_q == S_ACK) && we_q && cur_ram;
        data_in_d = data_in_q;
        rd_ram_d  = rd_ram_q;
        if (ready_d && !cur_we) begin
            rd_ram_d  = cur_ram;
            data_in_d = periph_rdata;
        end
    end

    // State, latched request, peripheral and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            data_in_q  <= '0;
            rd_ram_q   <= 1'b0;
            led_q      <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            data_in_q  <= data_in_d;
            rd_ram_q   <= rd_ram_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
        end
    end

    // Single-port synchronous RAM; its read register is the RAM-side Data_in source.
    always_ff @(posedge clk) begin
        // NOTE: no reset here so the array and its read register map onto block RAM.
        if (ram_we) mem[ram_idx] <= wdata_q;
        if (ram_re) ram_rd_q <= mem[ram_idx];
    end

    // Data_in comes from whichever register the last read loaded.
    assign Data_in   = rd_ram_q ? ram_rd_q : data_in_q;
    assign MIO_ready = ready_q;
    assign led_out   = led_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: a driver issues requests and pushes
// the expected Data_in and ready cycle into a scoreboard; a monitor pops and
// compares on every MIO_ready pulse.
module tb_mio_bus_responder;

    localparam int RAM_DEPTH = 1024;
    localparam int RAM_WAIT  = 2;
    localparam logic [31:0] A_LED = 32'hE000_0000;
    localparam logic [31:0] A_SW  = 32'hF000_0000;
    localparam logic [31:0] A_CNT = 32'hF000_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CPU_MIO = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] Addr_out = '0;
    logic [31:0] Data_out = '0;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic [1:0]  state;

    mio_bus_responder #(.RAM_DEPTH(RAM_DEPTH), .RAM_WAIT(RAM_WAIT)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
        .MIO_ready(MIO_ready), .sw_in(sw_in), .led_out(led_out), .state(state)
    );

    always #5 clk = ~clk;

    // Edge index: counts rising edges seen while out of reset.
    int unsigned cyc = 0;
    always @(posedge clk) if (!reset) cyc++;

    typedef struct {
        logic [31:0] data;
        int unsigned at;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state.
    logic [31:0] ram_m [RAM_DEPTH];
    bit          ram_ok [RAM_DEPTH];
    logic [15:0] led_m = '0;
    logic [31:0] din_m = '0;
    logic [31:0] cnt_base = '0;
    int unsigned cnt_cyc = 0;
    bit          chained = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Counter value just before rising edge edge_idx.
    function automatic logic [31:0] cnt_before(input int unsigned edge_idx);
        return cnt_base + 32'(edge_idx - 1 - cnt_cyc);
    endfunction

    function automatic void model_reset();
        led_m    = '0;
        din_m    = '0;
        cnt_base = '0;
        cnt_cyc  = cyc;
        chained  = 1'b0;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (MIO_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_ready: got MIO_ready=1, wanted 0 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, " data"}, Data_in, mon_e.data);
                check({mon_e.tag, " ready_cycle"}, cyc, mon_e.at);
            end
        end
    end

    // One bus transaction. Called at a negedge with the DUT idle, or right at the
    // ACK negedge of a previous request issued with keep=1.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input bit keep, input string tag);
        int unsigned acc;
        logic [31:0] a;
        bit          is_ram;
        int          idx;
        exp_t        e;
        bit          seen;
        acc    = chained ? cyc + 2 : cyc + 1;
        a      = addr & 32'hFFFF_FFFC;
        is_ram = (a < RAM_DEPTH * 4);
        idx    = is_ram ? int'(a >> 2) : 0;
        if (we) begin
            if (is_ram) begin
                ram_m[idx]  = data;
                ram_ok[idx] = 1'b1;
            end else if (a == A_LED) begin
                led_m = data[15:0];
            end else if (a == A_CNT) begin
                cnt_base = data;
                cnt_cyc  = acc + 1;
            end
        end else begin
            if (is_ram)          din_m = ram_m[idx];
            else if (a == A_LED) din_m = {16'h0, led_m};
            else if (a == A_SW)  din_m = {16'h0, sw_in};
            else if (a == A_CNT) din_m = cnt_before(acc);
            else                 din_m = 32'h0;
        end
        e.data = din_m;
        e.at   = acc + ((is_ram && RAM_WAIT > 0) ? RAM_WAIT : 0);
        e.tag  = tag;
        exp_q.push_back(e);

        Addr_out = addr;
        Data_out = data;
        mem_w    = we;
        CPU_MIO  = 1'b1;
        if (chained) @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (MIO_ready) begin
                seen = 1'b1;
            end else begin
                // Bus garbage after acceptance must not affect the transaction.
                Addr_out = $urandom;
                Data_out = $urandom;
                mem_w    = 1'($urandom);
                if (!keep && $urandom_range(0, 3) == 0) CPU_MIO = 1'b0;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got no MIO_ready, wanted one within 40 cycles", tag);
        end
        if (keep) begin
            chained = 1'b1;
        end else begin
            CPU_MIO = 1'b0;
            chained = 1'b0;
            @(negedge clk);
            check({tag, " led_out"}, {16'h0, led_out}, {16'h0, led_m});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, wanted completion by 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_addr, r_data;
        bit          r_we, r_keep;
        int          k, idx;

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("reset state", {30'h0, state}, 32'd0);
        check("reset ready", {31'h0, MIO_ready}, 32'd0);
        check("reset data_in", Data_in, 32'h0);
        check("reset led", {16'h0, led_out}, 32'h0);
        @(negedge clk);

        // RAM write then read back.
        txn(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, "ram_wr");
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, "ram_rd");

        // Peripherals.
        txn(1'b1, A_LED, 32'hABCD_00FF, 1'b0, "led_wr");
        check("led value", {16'h0, led_out}, 32'h0000_00FF);
        sw_in = 16'h5A5A;
        txn(1'b0, A_SW, 32'h0, 1'b0, "sw_rd");
        txn(1'b0, A_LED, 32'h0, 1'b0, "led_rd");

        // Asynchronous reset mid-cycle, no clock edge needed.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset state", {30'h0, state}, 32'd0);
        check("async reset ready", {31'h0, MIO_ready}, 32'd0);
        check("async reset data_in", Data_in, 32'h0);
        check("async reset led", {16'h0, led_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        // Counter load, wrap through zero, and elapsed-cycle reads.
        txn(1'b1, A_CNT, 32'hFFFF_FFFE, 1'b0, "cnt_wr");
        repeat (4) @(negedge clk);
        txn(1'b0, A_CNT, 32'h0, 1'b0, "cnt_wrap_rd");
        repeat (3) @(negedge clk);
        txn(1'b0, A_CNT, 32'h0, 1'b0, "cnt_rd2");

        // Unmapped accesses, RAM boundary word.
        txn(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, "unmap_wr");
        txn(1'b0, 32'h8000_0000, 32'h0, 1'b0, "unmap_rd");
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, "ram_after_unmap");
        txn(1'b1, 32'((RAM_DEPTH - 1) * 4), 32'hC0DE_F00D, 1'b0, "ram_top_wr");
        txn(1'b1, 32'(RAM_DEPTH * 4), 32'h1111_2222, 1'b0, "past_ram_wr");
        txn(1'b0, 32'((RAM_DEPTH - 1) * 4), 32'h0, 1'b0, "ram_top_rd");
        txn(1'b0, 32'(RAM_DEPTH * 4), 32'h0, 1'b0, "past_ram_rd");

        // Back-to-back with CPU_MIO held high.
        txn(1'b1, 32'h0000_0020, 32'hA5A5_0001, 1'b1, "b2b_ram_wr");
        txn(1'b1, A_CNT, 32'h0000_0100, 1'b1, "b2b_cnt_wr");
        txn(1'b0, 32'h0000_0020, 32'h0, 1'b0, "b2b_ram_rd");
        txn(1'b0, A_CNT, 32'h0, 1'b0, "b2b_cnt_rd");

        // Reset while a RAM write sits in WAIT: no ack, old data kept.
        Addr_out = 32'h0000_0020;
        Data_out = 32'h0BAD_0BAD;
        mem_w    = 1'b1;
        CPU_MIO  = 1'b1;
        @(negedge clk);
        check("in wait state", {30'h0, state}, 32'd1);
        reset   = 1'b1;
        CPU_MIO = 1'b0;
        #1;
        check("wait reset state", {30'h0, state}, 32'd0);
        check("wait reset ready", {31'h0, MIO_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        txn(1'b0, 32'h0000_0020, 32'h0, 1'b0, "ram_after_reset");

        // Randomized traffic over all targets.
        for (int n = 0; n < 200; n++) begin
            if (!chained) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sw_in = 16'($urandom);
            end
            k      = $urandom_range(0, 9);
            r_data = $urandom;
            r_we   = 1'($urandom);
            case (k)
                0, 1, 2, 3, 4: begin
                    idx    = ($urandom_range(0, 2) == 0) ? RAM_DEPTH - 1 : $urandom_range(0, 63);
                    r_addr = 32'(idx * 4);
                    if (!r_we && !ram_ok[idx]) r_we = 1'b1;
                end
                5, 9:    r_addr = A_LED;
                6:       r_addr = A_SW;
                7:       r_addr = A_CNT;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       r_addr = 32'(RAM_DEPTH * 4);
                        1:       r_addr = 32'h8000_0000;
                        2:       r_addr = 32'hF000_0008;
                        default: r_addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
                    endcase
                end
            endcase
            r_addr = r_addr | ($urandom & 32'h3);
            r_keep = (n < 199) && ($urandom_range(0, 3) == 0);
            txn(r_we, r_addr, r_data, r_keep, $sformatf("rand%0d", n));
        end

        repeat (5) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
